// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left (serial or rotate), parallel
// load, with a saturating shift counter and a one-cycle done pulse when the
// counter first reaches WIDTH.
module univ_shift_reg #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int             CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             rotate,
    input  logic             ser_in_msb,
    input  logic             ser_in_lsb,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] parallel_out,
    output logic             ser_out_msb,
    output logic             ser_out_lsb,
    output logic [CW-1:0]    shift_cnt,
    output logic             done
);

    localparam logic [1:0] M_HOLD  = 2'b00;
    localparam logic [1:0] M_SHR   = 2'b01;
    localparam logic [1:0] M_SHL   = 2'b10;
    localparam logic [1:0] M_LOAD  = 2'b11;

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             is_shift;

    // Both shift directions count identically, rotate or not.
    assign is_shift = (mode == M_SHR) || (mode == M_SHL);

    // Next data value: the incoming bit is either the serial input or the bit
    // falling off the opposite end, so the unused serial input never reaches data.
    always_comb begin
        data_d = data_q;
        unique case (mode)
            M_HOLD: data_d = data_q;
            M_SHR:  data_d = {(rotate ? data_q[0] : ser_in_msb), data_q[WIDTH-1:1]};
            M_SHL:  data_d = {data_q[WIDTH-2:0], (rotate ? data_q[WIDTH-1] : ser_in_lsb)};
            M_LOAD: data_d = parallel_in;
            default: data_d = data_q;
        endcase
    end

    // Counter saturates at WIDTH; done fires only on the WIDTH-1 -> WIDTH step,
    // so it cannot re-fire while saturated and always drops after one cycle.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (mode == M_LOAD) begin
            cnt_d = '0;
        end else if (is_shift && (cnt_q != CNT_MAX)) begin
            cnt_d  = cnt_q + 1'b1;
            done_d = (cnt_q == CNT_MAX - 1'b1);
        end
    end

    // State registers with immediate asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= RESET_VAL;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign parallel_out = data_q;
    assign ser_out_msb  = data_q[WIDTH-1];
    assign ser_out_lsb  = data_q[0];
    assign shift_cnt    = cnt_q;
    assign done         = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8, RESET_VAL=0). Each step pushes
// the expected post-edge state into a scoreboard queue; it is popped and
// compared one time unit after the clock edge.
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          rotate = 1'b0;
    logic          ser_in_msb = 1'b0;
    logic          ser_in_lsb = 1'b0;
    logic [W-1:0]  parallel_in = '0;
    logic [W-1:0]  parallel_out;
    logic          ser_out_msb;
    logic          ser_out_lsb;
    logic [CW-1:0] shift_cnt;
    logic          done;

    univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode         (mode),
        .rotate       (rotate),
        .ser_in_msb   (ser_in_msb),
        .ser_in_lsb   (ser_in_lsb),
        .parallel_in  (parallel_in),
        .parallel_out (parallel_out),
        .ser_out_msb  (ser_out_msb),
        .ser_out_lsb  (ser_out_lsb),
        .shift_cnt    (shift_cnt),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [CW-1:0] cnt;
        logic          done;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   done_seen = 0;

    // Reference state, updated from the behavioural description.
    logic [W-1:0]  m_data = '0;
    logic [CW-1:0] m_cnt  = '0;
    logic          m_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, predict, clock, then compare.
    task automatic step(input logic [1:0] m, input logic rot, input logic sm,
                        input logic sl, input logic [W-1:0] pin);
        exp_t e;
        logic [W-1:0] nd;
        logic [CW-1:0] nc;
        logic ndn;
        logic sh;
        mode = m; rotate = rot; ser_in_msb = sm; ser_in_lsb = sl; parallel_in = pin;
        sh  = (m == 2'b01) || (m == 2'b10);
        nd  = m_data;
        nc  = m_cnt;
        ndn = 1'b0;
        case (m)
            2'b01: nd = {(rot ? m_data[0] : sm), m_data[W-1:1]};
            2'b10: nd = {m_data[W-2:0], (rot ? m_data[W-1] : sl)};
            2'b11: nd = pin;
            default: nd = m_data;
        endcase
        if (m == 2'b11) nc = '0;
        else if (sh && m_cnt < CW'(W)) begin
            nc  = m_cnt + 1'b1;
            ndn = (m_cnt == CW'(W - 1));
        end
        m_data = nd; m_cnt = nc; m_done = ndn;
        q.push_back('{data: nd, cnt: nc, done: ndn});
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            chk("parallel_out", 32'(parallel_out), 32'(e.data));
            chk("shift_cnt",    32'(shift_cnt),    32'(e.cnt));
            chk("done",         32'(done),         32'(e.done));
            chk("ser_out_lsb",  32'(ser_out_lsb),  32'(e.data[0]));
            chk("ser_out_msb",  32'(ser_out_msb),  32'(e.data[W-1]));
        end
        if (done === 1'b1) done_seen++;
    endtask

    // Assert reset between edges and check outputs without any clock edge.
    task automatic async_reset(input string tag);
        mode = 2'b00;
        #1 rst_n = 1'b0;
        #1;
        chk({tag, "_data"}, 32'(parallel_out), 32'h00);
        chk({tag, "_cnt"},  32'(shift_cnt),    32'd0);
        chk({tag, "_done"}, 32'(done),         32'd0);
        m_data = '0; m_cnt = '0; m_done = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] a5;
        logic [W-1:0] sl_seq;

        // 1: reset visible before the first clock edge
        #3;
        chk("t1_data", 32'(parallel_out), 32'h00);
        chk("t1_cnt",  32'(shift_cnt),    32'd0);
        chk("t1_done", 32'(done),         32'd0);
        #1 rst_n = 1'b1;

        // 2: load A5, shift right 8 times with zero fill
        step(2'b11, 1'b0, 1'b0, 1'b0, 8'hA5);
        a5 = 8'hA5;
        done_seen = 0;
        for (int i = 0; i < W; i++) begin
            chk("t2_ser_lsb_seq", 32'(ser_out_lsb), 32'(a5[i]));
            step(2'b01, 1'b0, 1'b0, 1'b1, 8'h00);
            if (i == W - 1) chk("t2_done_8th", 32'(done), 32'd1);
        end
        chk("t2_final_data", 32'(parallel_out), 32'h00);
        chk("t2_final_cnt",  32'(shift_cnt),    32'd8);
        step(2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("t2_done_pulses", 32'(done_seen), 32'd1);

        // 3: rotates
        step(2'b11, 1'b0, 1'b0, 1'b0, 8'h81);
        step(2'b10, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("t3_rotl", 32'(parallel_out), 32'h03);
        step(2'b01, 1'b1, 1'b0, 1'b0, 8'h00);
        step(2'b01, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("t3_rotr", 32'(parallel_out), 32'hC0);
        chk("t3_cnt",  32'(shift_cnt),    32'd3);

        // 4: deserialise from reset, then saturate
        async_reset("t4_rst");
        sl_seq = 8'b1101_0010;
        done_seen = 0;
        for (int i = W - 1; i >= 0; i--) step(2'b10, 1'b0, 1'b1, sl_seq[i], 8'h00);
        chk("t4_data", 32'(parallel_out), 32'hD2);
        for (int i = 0; i < 3; i++) begin
            step(2'b10, 1'b0, 1'b0, 1'b1, 8'h00);
            chk("t4_sat_cnt",  32'(shift_cnt), 32'd8);
            chk("t4_sat_done", 32'(done),      32'd0);
        end
        chk("t4_done_pulses", 32'(done_seen), 32'd1);

        // 5: reset in the middle of a shift sequence
        step(2'b11, 1'b0, 1'b0, 1'b0, 8'h3C);
        for (int i = 0; i < 4; i++) step(2'b01, 1'b0, 1'b1, 1'b0, 8'h00);
        async_reset("t5_rst");
        step(2'b00, 1'b0, 1'b1, 1'b1, 8'hFF);
        step(2'b00, 1'b0, 1'b1, 1'b1, 8'hFF);
        chk("t5_hold", 32'(parallel_out), 32'h00);

        // 6: load while done is high
        for (int i = 0; i < W; i++) step(2'b10, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("t6_done_hi", 32'(done), 32'd1);
        step(2'b11, 1'b0, 1'b0, 1'b0, 8'hFF);
        chk("t6_data", 32'(parallel_out), 32'hFF);
        chk("t6_cnt",  32'(shift_cnt),    32'd0);
        chk("t6_done", 32'(done),         32'd0);

        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
